// File: rtl/mpc_grid_switch.sv
// Purpose : routes the west/east/north pad rings of an NH x NV macro grid to one owning macro each,
//           with a hitless (all-oe-low guard window) reconfiguration; build option MPC_IN_SYNC_EN.
// Latency : pad outputs registered, 1 cycle; north input fanout 0 cycles (2 with MPC_IN_SYNC_EN).
// Backpr. : cfg_ready is high only in IDLE; a request held while switching waits for the next IDLE.
module mpc_grid_switch #(
  parameter int NH           = 2,
  parameter int NV           = 2,
  parameter int NW           = 14,
  parameter int NN           = 10,
  parameter int GUARD_CYCLES = 8,
  parameter int RESET_CFG    = 0,
  localparam int RB          = $clog2(NV) + 1,
  localparam int CB          = $clog2(NH) + 1,
  localparam int CW          = 2*RB + CB
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CW-1:0]       cfg,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CW-1:0]       cfg_active,
  output logic                switching,
  input  logic [NH*NV*NW-1:0] west_o,
  input  logic [NH*NV*NW-1:0] west_oe,
  input  logic [NH*NV*NW-1:0] east_o,
  input  logic [NH*NV*NW-1:0] east_oe,
  input  logic [NH*NV*NN-1:0] north_o,
  input  logic [NH*NV*NN-1:0] north_oe,
  output logic [NW-1:0]       io_west_o,
  output logic [NW-1:0]       io_west_oe,
  output logic [NW-1:0]       io_east_o,
  output logic [NW-1:0]       io_east_oe,
  output logic [NN-1:0]       io_north_o,
  output logic [NN-1:0]       io_north_oe,
  input  logic [NN-1:0]       io_north_i,
  output logic [NH*NN-1:0]    north_i
);

  // Guard counter holds GUARD_CYCLES-1 down to 0.
  localparam int GW = $clog2(GUARD_CYCLES) + 1;
  localparam logic [CW-1:0] RST_CFG = CW'(RESET_CFG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t          r_state, w_state_nx;
  logic [GW-1:0]   r_cnt, w_cnt_nx;
  logic [CW-1:0]   r_pend, w_pend_nx;
  logic [CW-1:0]   r_active, w_active_nx;
  logic            w_ready;
  logic            w_switching;

  // Config fields of the live routing.
  logic [RB-1:0]   w_west_row;
  logic [RB-1:0]   w_east_row;
  logic [CB-1:0]   w_north_col;

  assign w_west_row  = r_active[RB-1:0];
  assign w_east_row  = r_active[2*RB-1:RB];
  assign w_north_col = r_active[CW-1:2*RB];

  // Selected (combinational) pad values before the output register.
  logic [NW-1:0]   w_west_o_sel, w_west_oe_sel;
  logic [NW-1:0]   w_east_o_sel, w_east_oe_sel;
  logic [NN-1:0]   w_north_o_sel, w_north_oe_sel;

  // Registered pad values.
  logic [NW-1:0]   r_west_o, r_west_oe, r_east_o, r_east_oe;
  logic [NN-1:0]   r_north_o, r_north_oe;

  // North pad input as seen by the fanout, and the fanout itself.
  logic [NN-1:0]   w_nin;
  logic [NH*NN-1:0] w_north_i;

  // FSM state register together with guard counter, pending and active config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pend   <= '0;
      r_active <= RST_CFG;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_pend   <= w_pend_nx;
      r_active <= w_active_nx;
    end
  end

  // FSM next state: accept in IDLE, blank for GUARD_CYCLES, one APPLY cycle commits the new routing.
  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_pend_nx   = r_pend;
    w_active_nx = r_active;
    w_ready     = 1'b0;
    w_switching = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (cfg_valid) begin
          // An identical config still goes through the full blank so behaviour is uniform.
          w_pend_nx  = cfg;
          w_cnt_nx   = GW'(GUARD_CYCLES - 1);
          w_state_nx = S_BLANK;
        end
      end
      S_BLANK: begin
        w_switching = 1'b1;
        if (r_cnt == '0) begin
          w_state_nx = S_APPLY;
        end else begin
          w_cnt_nx = r_cnt - GW'(1);
        end
      end
      S_APPLY: begin
        w_switching = 1'b1;
        w_active_nx = r_pend;
        w_state_nx  = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign cfg_ready  = w_ready;
  assign switching  = w_switching;
  assign cfg_active = r_active;

  // West/east mux: row match against col 0 / col NH-1; an out-of-range row matches nothing -> 0.
  always_comb begin
    w_west_o_sel  = '0;
    w_west_oe_sel = '0;
    w_east_o_sel  = '0;
    w_east_oe_sel = '0;
    for (int r = 0; r < NV; r++) begin
      if (w_west_row == RB'(r)) begin
        w_west_o_sel  = west_o [(r*NH) * NW +: NW];
        w_west_oe_sel = west_oe[(r*NH) * NW +: NW];
      end
      if (w_east_row == RB'(r)) begin
        w_east_o_sel  = east_o [(r*NH + NH - 1) * NW +: NW];
        w_east_oe_sel = east_oe[(r*NH + NH - 1) * NW +: NW];
      end
    end
  end

  // North mux: column match in the top row; an out-of-range column matches nothing -> 0.
  always_comb begin
    w_north_o_sel  = '0;
    w_north_oe_sel = '0;
    for (int c = 0; c < NH; c++) begin
      if (w_north_col == CB'(c)) begin
        w_north_o_sel  = north_o [((NV-1)*NH + c) * NN +: NN];
        w_north_oe_sel = north_oe[((NV-1)*NH + c) * NN +: NN];
      end
    end
  end

  // Pad output register: routed values only in IDLE, forced to 0 while blanking/applying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_west_o   <= '0;
      r_west_oe  <= '0;
      r_east_o   <= '0;
      r_east_oe  <= '0;
      r_north_o  <= '0;
      r_north_oe <= '0;
    end else if (r_state == S_IDLE) begin
      r_west_o   <= w_west_o_sel;
      r_west_oe  <= w_west_oe_sel;
      r_east_o   <= w_east_o_sel;
      r_east_oe  <= w_east_oe_sel;
      r_north_o  <= w_north_o_sel;
      r_north_oe <= w_north_oe_sel;
    end else begin
      r_west_o   <= '0;
      r_west_oe  <= '0;
      r_east_o   <= '0;
      r_east_oe  <= '0;
      r_north_o  <= '0;
      r_north_oe <= '0;
    end
  end

  assign io_west_o   = r_west_o;
  assign io_west_oe  = r_west_oe;
  assign io_east_o   = r_east_o;
  assign io_east_oe  = r_east_oe;
  assign io_north_o  = r_north_o;
  assign io_north_oe = r_north_oe;

`ifdef MPC_IN_SYNC_EN
  logic [NN-1:0] r_nin_s1, r_nin_s2;

  // Two-flop synchroniser for the asynchronous north pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nin_s1 <= '0;
      r_nin_s2 <= '0;
    end else begin
      r_nin_s1 <= io_north_i;
      r_nin_s2 <= r_nin_s1;
    end
  end

  assign w_nin = r_nin_s2;
`else
  assign w_nin = io_north_i;
`endif

  // Fan north input to the owning column only, and only while the routing is live.
  always_comb begin
    w_north_i = '0;
    for (int c = 0; c < NH; c++) begin
      if ((r_state == S_IDLE) && (w_north_col == CB'(c))) begin
        w_north_i[c*NN +: NN] = w_nin;
      end
    end
  end

  assign north_i = w_north_i;

endmodule
